// File: rtl/router_arb_pkg.sv
// Shared types for the router packet-buffer arbiter.
// State and round-robin encodings used across the arbiter slice.
package router_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    READ_BURST  = 2'd1,
    WRITE_BURST = 2'd2
  } arb_state_e;

  typedef enum logic {
    SRV_READ  = 1'b0,
    SRV_WRITE = 1'b1
  } served_e;

  localparam int unsigned DEF_BURST_LEN = 5;

endpackage

// File: rtl/router_burst_addr_gen.sv
// Burst base latch and beat counter, shared by read and write bursts.
// Produces the wrapped beat address and a last-beat flag.
module router_burst_addr_gen
  import router_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_in,
  input  logic                  advance,
  input  logic                  clear,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [ADDR_WIDTH-1:0] base;
  logic [BW-1:0]         beat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base <= '0;
      beat <= '0;
    end else if (load) begin
      base <= base_in;
      beat <= '0;
    end else if (clear || (advance && last)) begin
      beat <= '0;
    end else if (advance) begin
      beat <= beat + BW'(1);
    end
  end

  // >= keeps the flag asserted if the counter ever overshoots
  assign last = (beat >= LAST_BEAT);
  assign addr = base + ADDR_WIDTH'(beat);

endmodule

// File: rtl/router_mem_arbiter.sv
// Grants read/write bursts from the router controller onto one
// single-port packet buffer, round-robin under contention.
module router_mem_arbiter
  import router_arb_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int BURST_LEN         = DEF_BURST_LEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         read_req,
  input  logic [ADDR_WIDTH-1:0]        read_src_addr,
  output logic                         read_gnt,
  output logic                         read_done,
  output logic [AURORA_DATA_WIDTH-1:0] rd_data,
  output logic                         rd_data_valid,
  input  logic                         write_req,
  input  logic [ADDR_WIDTH-1:0]        write_dst_addr,
  input  logic [AURORA_DATA_WIDTH-1:0] write_data,
  output logic                         write_gnt,
  output logic                         write_done,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [AURORA_DATA_WIDTH-1:0] mem_wdata,
  input  logic [AURORA_DATA_WIDTH-1:0] mem_rdata
);

  arb_state_e state, state_nx;
  served_e    last_served, served_nx;

  logic                  load;
  logic                  advance;
  logic                  clear;
  logic                  last;
  logic [ADDR_WIDTH-1:0] base_in;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  rd_valid_q;

  router_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .base_in(base_in),
    .advance(advance),
    .clear  (clear),
    .addr   (addr),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SRV_WRITE;
      rd_valid_q  <= 1'b0;
    end else begin
      state       <= state_nx;
      last_served <= served_nx;
      rd_valid_q  <= read_gnt;
    end
  end

  always_comb begin
    state_nx  = state;
    served_nx = last_served;
    load      = 1'b0;
    base_in   = read_src_addr;
    advance   = 1'b0;
    clear     = 1'b0;
    read_gnt  = 1'b0;
    write_gnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (read_req && (!write_req || last_served == SRV_WRITE)) begin
          state_nx = READ_BURST;
          load     = 1'b1;
          base_in  = read_src_addr;
        end else if (write_req) begin
          state_nx = WRITE_BURST;
          load     = 1'b1;
          base_in  = write_dst_addr;
        end
      end
      READ_BURST: begin
        read_gnt = read_req;
        advance  = read_req;
        clear    = !read_req;
        if (!read_req || last) begin
          state_nx  = IDLE;
          served_nx = SRV_READ;
        end
      end
      WRITE_BURST: begin
        write_gnt = write_req;
        advance   = write_req;
        clear     = !write_req;
        if (!write_req || last) begin
          state_nx  = IDLE;
          served_nx = SRV_WRITE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign read_done     = read_gnt && last;
  assign write_done    = write_gnt && last;
  assign mem_en        = read_gnt || write_gnt;
  assign mem_we        = write_gnt;
  assign mem_addr      = mem_en ? addr : '0;
  assign mem_wdata     = write_gnt ? write_data : '0;
  assign rd_data       = mem_rdata;
  assign rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Scoreboard bench for router_mem_arbiter with a 1-cycle RAM model.
// Read data expectations are queued at grant time and popped on valid.
module tb_router_mem_arbiter;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BL = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          read_req;
  logic [AW-1:0] read_src_addr;
  logic          read_gnt;
  logic          read_done;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          write_req;
  logic [AW-1:0] write_dst_addr;
  logic [DW-1:0] write_data;
  logic          write_gnt;
  logic          write_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] mem [1024];
  logic [DW-1:0] exp_mem [1024];
  logic          loaded = 1'b0;
  logic [DW-1:0] rdq [$];
  int            n_checks = 0;
  int            n_err = 0;
  int            rdv_cnt = 0;
  int            rdv_base;

  router_mem_arbiter #(
    .AURORA_DATA_WIDTH(DW),
    .ADDR_WIDTH       (AW),
    .BURST_LEN        (BL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_req      (read_req),
    .read_src_addr (read_src_addr),
    .read_gnt      (read_gnt),
    .read_done     (read_done),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .write_req     (write_req),
    .write_dst_addr(write_dst_addr),
    .write_data    (write_data),
    .write_gnt     (write_gnt),
    .write_done    (write_done),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] <= DW'(i);
      loaded <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_data_valid) begin
      rdv_cnt++;
      if (rdq.size() == 0) chk("rd_unexpected", 64'(rdq.size()), 64'd1);
      else chk("rd_data", rd_data, rdq.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic rg, input logic wg,
                     input logic [AW-1:0] a, input logic dn,
                     input logic [DW-1:0] wd);
    @(negedge clk);
    chk({tag, " read_gnt"}, 64'(read_gnt), 64'(rg));
    chk({tag, " write_gnt"}, 64'(write_gnt), 64'(wg));
    chk({tag, " mem_en"}, 64'(mem_en), 64'(rg | wg));
    chk({tag, " mem_we"}, 64'(mem_we), 64'(wg));
    chk({tag, " mem_addr"}, 64'(mem_addr), (rg | wg) ? 64'(a) : 64'd0);
    chk({tag, " read_done"}, 64'(read_done), 64'(rg & dn));
    chk({tag, " write_done"}, 64'(write_done), 64'(wg & dn));
    chk({tag, " mem_wdata"}, mem_wdata, wg ? wd : 64'd0);
    if (rg) rdq.push_back(exp_mem[a]);
    if (wg) exp_mem[a] = wd;
  endtask

  task automatic read_seq(input string tag, input logic [AW-1:0] base,
                          input int n);
    step();
    read_req = 1'b1;
    read_src_addr = base;
    cyc({tag, "_lat"}, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < n; k++) begin
      step();
      read_src_addr = ~base;
      cyc(tag, 1'b1, 1'b0, base + AW'(k), k == BL - 1, '0);
    end
    step();
    read_req = 1'b0;
    cyc({tag, "_end"}, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic write_seq(input string tag, input logic [AW-1:0] base,
                           input logic [DW-1:0] d0);
    step();
    write_req = 1'b1;
    write_dst_addr = base;
    cyc({tag, "_lat"}, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < BL; k++) begin
      step();
      write_dst_addr = ~base;
      write_data = d0 + DW'(k);
      cyc(tag, 1'b0, 1'b1, base + AW'(k), k == BL - 1, d0 + DW'(k));
    end
    step();
    write_req = 1'b0;
    cyc({tag, "_end"}, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, " read_gnt"}, 64'(read_gnt), 64'd0);
    chk({tag, " write_gnt"}, 64'(write_gnt), 64'd0);
    chk({tag, " read_done"}, 64'(read_done), 64'd0);
    chk({tag, " write_done"}, 64'(write_done), 64'd0);
    chk({tag, " rd_valid"}, 64'(rd_data_valid), 64'd0);
    chk({tag, " mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    read_req = 1'b0;
    write_req = 1'b0;
    read_src_addr = '0;
    write_dst_addr = '0;
    write_data = '0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_chk("reset");
    chk("reset rd_data", rd_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // contention straight after reset: read, write, read
    read_req = 1'b1;
    write_req = 1'b1;
    read_src_addr = 10'h020;
    write_dst_addr = 10'h200;
    cyc("rr_lat", 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < BL; k++) begin
      step();
      cyc("rr_rd1", 1'b1, 1'b0, 10'h020 + AW'(k), k == BL - 1, '0);
    end
    step();
    cyc("rr_gap1", 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < BL; k++) begin
      step();
      write_data = 64'h55 + DW'(k);
      cyc("rr_wr", 1'b0, 1'b1, 10'h200 + AW'(k), k == BL - 1,
          64'h55 + DW'(k));
    end
    step();
    cyc("rr_gap2", 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < BL; k++) begin
      step();
      cyc("rr_rd2", 1'b1, 1'b0, 10'h020 + AW'(k), k == BL - 1, '0);
    end
    step();
    read_req = 1'b0;
    write_req = 1'b0;
    cyc("rr_end", 1'b0, 1'b0, '0, 1'b0, '0);

    read_seq("rd", 10'h010, BL);
    write_seq("wr", 10'h100, 64'hA0);
    read_seq("rdback", 10'h100, BL);
    read_seq("wrap", 10'h3FE, BL);

    step();
    rdv_base = rdv_cnt;
    read_seq("abort", 10'h040, 2);
    step();
    step();
    chk("abort rd_valid pulses", 64'(rdv_cnt - rdv_base), 64'd2);
    read_seq("restart", 10'h050, BL);

    // reset lands in the third beat of a write burst
    step();
    write_req = 1'b1;
    write_dst_addr = 10'h300;
    cyc("rst_wr_lat", 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      step();
      write_data = 64'hC0 + DW'(k);
      cyc("rst_wr", 1'b0, 1'b1, 10'h300 + AW'(k), 1'b0, 64'hC0 + DW'(k));
    end
    step();
    write_data = 64'hDEAD;
    #2 rst_n = 1'b0;
    #1 zero_chk("async_rst");
    write_dst_addr = 10'h180;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("post_rst_lat", 1'b0, 1'b0, '0, 1'b0, '0);
    for (int k = 0; k < BL; k++) begin
      step();
      write_data = 64'hB0 + DW'(k);
      cyc("post_rst_wr", 1'b0, 1'b1, 10'h180 + AW'(k), k == BL - 1,
          64'hB0 + DW'(k));
    end
    step();
    write_req = 1'b0;
    cyc("post_rst_end", 1'b0, 1'b0, '0, 1'b0, '0);
    read_seq("rst_rdback", 10'h180, BL);
    read_seq("pre_rst_rdback", 10'h300, 3);

    repeat (3) step();
    chk("rd queue drained", 64'(rdq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/router_mem_arbiter.md
Name: router_mem_arbiter

Overview:
- Responder side of the router controller's arbiter handshake: accepts read requests (source address) and write requests (destination address) and grants them burst by burst.
- Sequences the granted accesses onto one shared single-port packet buffer memory.
- Returns read data with a valid strobe.
- Sits between the router controller / output-port logic and the buffer RAM.

Parameters:
AURORA_DATA_WIDTH, 64, data beat width
ADDR_WIDTH, 10, buffer address width
BURST_LEN, 5, beats granted per burst (min 1, max 2^ADDR_WIDTH)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
read_req  input  1  read request, held high by requester for the whole burst
read_src_addr  input  ADDR_WIDTH  burst base address, sampled at burst start
read_gnt  output  1  one beat of the read burst accepted this cycle
read_done  output  1  one-cycle pulse on the last read beat
rd_data  output  AURORA_DATA_WIDTH  read beat data
rd_data_valid  output  1  rd_data valid
write_req  input  1  write request, held high for the whole burst
write_dst_addr  input  ADDR_WIDTH  burst base address, sampled at burst start
write_data  input  AURORA_DATA_WIDTH  write beat data, consumed when write_gnt=1
write_gnt  output  1  write beat accepted this cycle
write_done  output  1  one-cycle pulse on the last write beat
mem_en  output  1  memory access enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  AURORA_DATA_WIDTH  memory write data
mem_rdata  input  AURORA_DATA_WIDTH  memory read data, 1-cycle latency after mem_en with mem_we=0

Behaviour:
- Clock: single clock, clk. Reset: rst_n, asynchronous, active-low.
- Reset values:
  - state=IDLE, beat counter=0, base register=0, last_served=WRITE.
  - All outputs 0.
  - Asserting reset mid-burst aborts the burst; nothing resumes after reset.
- States: IDLE, READ_BURST, WRITE_BURST (encoding from the package).
- IDLE:
  - Only read_req high -> latch read_src_addr, go to READ_BURST.
  - Only write_req high -> latch write_dst_addr, go to WRITE_BURST.
  - Both high -> serve the type opposite to last_served (round-robin). The first contention after reset goes to read.
  - No grants are issued while in IDLE.
  - Grant latency is 1 cycle after the request is first seen in IDLE.
- READ_BURST, each cycle with read_req=1:
  - read_gnt=1, mem_en=1, mem_we=0, mem_addr=base+beat.
  - Beat counter increments.
- WRITE_BURST, each cycle with write_req=1:
  - write_gnt=1, mem_en=1, mem_we=1, mem_addr=base+beat, mem_wdata=write_data.
  - Beat counter increments.
- grant, mem_en, mem_we, mem_addr and mem_wdata are combinational from state, beat counter and req. All other state is registered.
- Last beat (beat==BURST_LEN-1):
  - read_done or write_done pulses in the same cycle as the grant.
  - last_served updates; counter clears; state returns to IDLE.
  - There is always at least one IDLE cycle between bursts.
- Abort: req deasserts mid-burst -> no grant that cycle, no done pulse, counter clears, return to IDLE. last_served updates as for completion.
- The other request type is never granted during a burst; requests are not queued.
- Address arithmetic: base+beat is modulo 2^ADDR_WIDTH, so 1023+1 -> 0 at ADDR_WIDTH=10.
- Read return:
  - rd_data_valid is registered read_gnt, i.e. 1 cycle after each read grant.
  - rd_data = mem_rdata, passthrough.
  - rd_data_valid still fires for the final beat even if the burst aborts right after it.
- Beat counter width is clog2(BURST_LEN)+1 and saturates safely.

Decomposition:
- Shared package router_arb_pkg:
  - state enum IDLE/READ_BURST/WRITE_BURST.
  - last_served encoding (READ=0, WRITE=1).
  - default BURST_LEN constant.
- One natural sub-module: router_burst_addr_gen, holding the base-address latch, beat counter, wrapped address output and last-beat flag. It is instantiated once and shared by both burst types.

Test Plan:
1. Read burst: read_req=1, read_src_addr=0x010, BURST_LEN=5, memory preloaded mem[k]=k -> read_gnt high 5 cycles starting 1 cycle after req, mem_addr 0x010..0x014, read_done on 5th grant, rd_data_valid 5 cycles lagging 1 with data 0x10..0x14.
2. Write burst: write_req=1, write_dst_addr=0x100, write_data=0xA0..0xA4 advanced per grant -> mem_we=1 for 5 cycles at 0x100..0x104, write_done on last beat; readback returns 0xA0..0xA4.
3. Simultaneous requests after reset: read_req and write_req both high -> read burst first (5 grants), 1 IDLE cycle, then write burst; repeating with both still high alternates read/write.
4. Address wrap: read_src_addr=0x3FE -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001, 0x002.
5. Abort: read_req dropped after 2 grants -> no 3rd grant, no read_done, state IDLE next cycle, 2 rd_data_valid pulses; a new request restarts at beat 0 with a freshly latched address.
6. Reset mid-burst: rst_n low during beat 3 of a write burst -> all outputs 0 immediately (asynchronous); after release with write_req still high, a fresh burst starts at beat 0.
